apb_master_arbiter: RTL

Two-port APB arbiter that shares the single peripheral APB bus (UART, GPIO A/B behind the slave mux) between two upstream APB masters: port 0 is the AHB-to-APB bridge, port 1 is a secondary master such as a config/boot sequencer or DMA. The arbiter grants the bus round-robin, registers the address/control phase of the winner, and runs a standard SETUP/ACCESS sequence downstream. It stalls the losing master through its PREADY. An optional watchdog terminates hung transfers with an error.

---
 rtl/apb_master_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one downstream APB bus between two upstream APB
// masters (port 0: AHB-to-APB bridge, port 1: secondary master).
// Round-robin grant in IDLE, registered address/control payload, and a plain
// SETUP/ACCESS sequence downstream. The losing master is stalled by holding
// its PREADY low until it has been granted and its transfer completes.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to enable the ACCESS-phase
// watchdog. It forces an error completion after TIMEOUT ACCESS cycles without
// PREADY and pulses ARB_TIMEOUT_IRQ. Without the macro ACCESS waits forever.
//
// Handshake: upstream, a master requests with Mi_PSEL and its transfer ends in
// the cycle where Mi_PREADY=1 (Mi_PSLVERR/Mi_PRDATA valid only then).
// Downstream, PSEL/PENABLE/payload follow APB; a transfer ends in the ACCESS
// cycle where PREADY=1 (or the watchdog fires). No preemption: the owner keeps
// the bus until that completion cycle.

module apb_master_arbiter #(
    parameter int ADDRWIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    // master 0
    input  logic                 M0_PSEL,
    input  logic                 M0_PENABLE,
    input  logic                 M0_PWRITE,
    input  logic [ADDRWIDTH-1:0] M0_PADDR,
    input  logic [31:0]          M0_PWDATA,
    input  logic [3:0]           M0_PSTRB,
    input  logic [2:0]           M0_PPROT,
    output logic [31:0]          M0_PRDATA,
    output logic                 M0_PREADY,
    output logic                 M0_PSLVERR,
    // master 1
    input  logic                 M1_PSEL,
    input  logic                 M1_PENABLE,
    input  logic                 M1_PWRITE,
    input  logic [ADDRWIDTH-1:0] M1_PADDR,
    input  logic [31:0]          M1_PWDATA,
    input  logic [3:0]           M1_PSTRB,
    input  logic [2:0]           M1_PPROT,
    output logic [31:0]          M1_PRDATA,
    output logic                 M1_PREADY,
    output logic                 M1_PSLVERR,
    // downstream
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR,
    output logic                 ARB_TIMEOUT_IRQ,
    // debug: current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } state_t;

    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("apb_master_arbiter: TIMEOUT must be in 1..255");
    end

    state_t                 r_state;
    logic                   r_owner;
    logic                   r_last_grant;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [ADDRWIDTH-1:0]   r_paddr;
    logic [31:0]            r_pwdata;
    logic [3:0]             r_pstrb;
    logic [2:0]             r_pprot;

    logic                   w_req_any;
    logic                   w_sel;
    logic                   w_sel_pwrite;
    logic [ADDRWIDTH-1:0]   w_sel_paddr;
    logic [31:0]            w_sel_pwdata;
    logic [3:0]             w_sel_pstrb;
    logic [2:0]             w_sel_pprot;
    logic                   w_access;
    logic                   w_own0;
    logic                   w_own1;
    logic                   w_timeout;
    logic                   w_done;
    logic                   w_unused;

    // Upstream PENABLE is not needed: ACCESS timing is generated here.
    assign w_unused = M0_PENABLE ^ M1_PENABLE;

    // Round-robin pick: on a tie the port not granted last wins.
    assign w_req_any    = M0_PSEL | M1_PSEL;
    assign w_sel        = (M0_PSEL & M1_PSEL) ? ~r_last_grant : M1_PSEL;
    assign w_sel_pwrite = w_sel ? M1_PWRITE : M0_PWRITE;
    assign w_sel_paddr  = w_sel ? M1_PADDR  : M0_PADDR;
    assign w_sel_pwdata = w_sel ? M1_PWDATA : M0_PWDATA;
    assign w_sel_pstrb  = w_sel ? M1_PSTRB  : M0_PSTRB;
    assign w_sel_pprot  = w_sel ? M1_PPROT  : M0_PPROT;

    assign w_access = (r_state == ST_ACCESS);
    assign w_own0   = w_access & ~r_owner;
    assign w_own1   = w_access &  r_owner;

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_wait_cnt;
    // PREADY in the last allowed cycle still wins as a normal completion.
    assign w_timeout = w_access & ~PREADY & (r_wait_cnt == TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done = w_access & (PREADY | w_timeout);

    // Response routing: only the owner in ACCESS sees the slave; others stall.
    assign M0_PREADY  = w_own0 & (PREADY | w_timeout);
    assign M1_PREADY  = w_own1 & (PREADY | w_timeout);
    assign M0_PSLVERR = w_own0 & (PREADY ? PSLVERR : w_timeout);
    assign M1_PSLVERR = w_own1 & (PREADY ? PSLVERR : w_timeout);
    assign M0_PRDATA  = (w_own0 & ~w_timeout) ? PRDATA : 32'd0;
    assign M1_PRDATA  = (w_own1 & ~w_timeout) ? PRDATA : 32'd0;

    assign ARB_TIMEOUT_IRQ = w_timeout;

    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PSTRB       = r_pstrb;
    assign PPROT       = r_pprot;
    assign o_dbg_state = r_state;

    // Arbitration FSM with registered bus control, payload and wait counter.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= 32'd0;
            r_pstrb      <= 4'd0;
            r_pprot      <= 3'd0;
`ifdef APB_ARB_TIMEOUT_EN
            r_wait_cnt   <= 8'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_owner      <= w_sel;
                        r_last_grant <= w_sel;
                        r_pwrite     <= w_sel_pwrite;
                        r_paddr      <= w_sel_paddr;
                        r_pwdata     <= w_sel_pwdata;
                        r_pstrb      <= w_sel_pstrb;
                        r_pprot      <= w_sel_pprot;
                        r_psel       <= 1'b1;
                        r_penable    <= 1'b0;
                        r_state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    r_wait_cnt <= 8'd0;
`endif
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
